// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified RV32 memory: one access in flight,
// ready-handshake memory side, one-cycle rvalid back to the owning port.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner, last_owner;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_wstrb;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        any_req, winner, grant, done_ok, done_to;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;

  // winner = 1 selects port 1; only meaningful while any_req is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner = p1_req;
    if (p0_req && p1_req)
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
  end

  assign any_req   = p0_req | p1_req;
  assign grant     = (state == IDLE) && any_req;
  assign done_ok   = (state == ACCESS) && mem_ready;
  assign done_to   = (state == ACCESS) && !mem_ready && (cnt == TO_LAST);

  assign sel_we    = winner ? p1_we    : p0_we;
  assign sel_addr  = winner ? p1_addr  : p0_addr;
  assign sel_wdata = winner ? p1_wdata : p0_wdata;
  assign sel_wstrb = winner ? p1_wstrb : p0_wstrb;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (done_ok || done_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the latched request fields are reset too, because they drive mem_* directly and must read 0 after reset.
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant) begin
        owner      <= winner;
        last_owner <= winner;
        lat_we     <= sel_we;
        lat_addr   <= sel_addr & 32'hFFFF_FFFC;
        lat_wdata  <= sel_wdata;
        lat_wstrb  <= sel_wstrb;
        cnt        <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 8'd1;
      if (done_ok) begin
        rdata_q <= lat_we ? 32'h0 : mem_rdata;
        err_q   <= 1'b0;
      end else if (done_to) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is high, since the edge would discard them anyway.
  always_comb begin
    p0_gnt    = grant && !winner && !reset;
    p1_gnt    = grant &&  winner && !reset;
    p0_rvalid = (state == RESP) && !owner;
    p1_rvalid = (state == RESP) &&  owner;
    busy      = (state != IDLE);
    mem_req   = (state == ACCESS);
    mem_we    = (state == ACCESS) && lat_we;
    mem_wstrb = ((state == ACCESS) && lat_we) ? lat_wstrb : 4'b0000;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    rdata     = rdata_q;
    err       = err_q;
  end

endmodule
